// File: rtl/rle_dec.sv
// Run-length decoder: expands {bit, length} words into an MSB-first byte stream.
// Optional RLE_DEC_STATS_EN adds byte_count and zero_run_err outputs.
module rle_dec #(
    parameter int COUNT_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               recv_ready,
    input  logic               send_ready,
    input  logic [COUNT_W:0]   in_data,
    input  logic               end_of_stream,
    output logic [7:0]         out_data,
    output logic               rd_req,
    output logic               wr_req
`ifdef RLE_DEC_STATS_EN
    ,
    output logic [31:0]        byte_count,
    output logic               zero_run_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        EXPAND,
        WRITE,
        FLUSH
    } state_t;

    state_t             state, state_n;
    logic [7:0]         byte_sr, sr_n;
    logic [7:0]         out_n;
    logic [3:0]         fill, fill_n;
    logic [COUNT_W-1:0] remaining, rem_n;
    logic               bit_val, bit_n;
    logic               eos_pending, eos_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_data    <= '0;
            byte_sr     <= '0;
            fill        <= '0;
            remaining   <= '0;
            bit_val     <= 1'b0;
            eos_pending <= 1'b0;
        end else begin
            state       <= state_n;
            out_data    <= out_n;
            byte_sr     <= sr_n;
            fill        <= fill_n;
            remaining   <= rem_n;
            bit_val     <= bit_n;
            eos_pending <= eos_n;
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = byte_sr;
        out_n   = out_data;
        fill_n  = fill;
        rem_n   = remaining;
        bit_n   = bit_val;
        eos_n   = eos_pending;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        unique case (state)
            IDLE: begin
                if (recv_ready) begin
                    state_n = READ;
                end else if (eos_pending && fill != 4'd0) begin
                    state_n = FLUSH;
                    out_n   = byte_sr << (4'd8 - fill);
                end else if (eos_pending) begin
                    eos_n = 1'b0;
                end
            end
            READ: begin
                rd_req  = 1'b1;
                state_n = LOAD;
            end
            LOAD: begin
                bit_n   = in_data[COUNT_W];
                rem_n   = in_data[COUNT_W-1:0];
                state_n = (rem_n == '0) ? IDLE : EXPAND;
            end
            EXPAND: begin
                sr_n   = {byte_sr[6:0], bit_val};
                fill_n = fill + 4'd1;
                if (remaining != '0) begin
                    rem_n = remaining - 1'b1;
                end
                if (fill_n == 4'd8) begin
                    state_n = WRITE;
                    out_n   = sr_n;
                end else if (rem_n == '0) begin
                    state_n = IDLE;
                end
            end
            WRITE: begin
                wr_req = send_ready;
                if (send_ready) begin
                    fill_n  = 4'd0;
                    state_n = (remaining != '0) ? EXPAND : IDLE;
                end
            end
            FLUSH: begin
                wr_req = send_ready;
                if (send_ready) begin
                    fill_n  = 4'd0;
                    eos_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A new end-of-stream pulse always wins over a same-cycle clear.
        if (end_of_stream) begin
            eos_n = 1'b1;
        end
    end

`ifdef RLE_DEC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count   <= '0;
            zero_run_err <= 1'b0;
        end else begin
            if (wr_req && byte_count != 32'hFFFF_FFFF) begin
                byte_count <= byte_count + 32'd1;
            end
            if (state == LOAD && in_data[COUNT_W-1:0] == '0) begin
                zero_run_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rle_dec.sv
// Self-checking bench for rle_dec: FIFO model on the input side, bit-queue
// reference model packing bytes; define RLE_DEC_STATS_EN to check statistics.
module tb_rle_dec;

    localparam int COUNT_W = 23;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               recv_ready = 1'b0;
    logic               send_ready = 1'b1;
    logic [COUNT_W:0]   in_data = '0;
    logic               end_of_stream = 1'b0;
    logic [7:0]         out_data;
    logic               rd_req;
    logic               wr_req;
`ifdef RLE_DEC_STATS_EN
    logic [31:0]        byte_count;
    logic               zero_run_err;
`endif

    rle_dec #(.COUNT_W(COUNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .recv_ready    (recv_ready),
        .send_ready    (send_ready),
        .in_data       (in_data),
        .end_of_stream (end_of_stream),
        .out_data      (out_data),
        .rd_req        (rd_req),
        .wr_req        (wr_req)
`ifdef RLE_DEC_STATS_EN
        ,
        .byte_count    (byte_count),
        .zero_run_err  (zero_run_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [COUNT_W:0] fifo[$];
    bit               bits[$];
    logic [7:0]       expq[$];
    logic [7:0]       got[$];
    int               rd_count = 0;
    int               wr_total = 0;
    int               bad_wr = 0;

    // Input FIFO: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        if (rd_req && fifo.size() != 0) begin
            in_data <= fifo.pop_front();
        end
        recv_ready <= (fifo.size() != 0);
    end

    always @(negedge clk) begin
        if (rd_req) rd_count++;
        if (wr_req && !send_ready) bad_wr++;
        if (wr_req && send_ready) begin
            got.push_back(out_data);
            wr_total++;
        end
    end

    task automatic model_word(input bit v, input int len);
        logic [7:0] b;
        for (int i = 0; i < len; i++) bits.push_back(v);
        while (bits.size() >= 8) begin
            b = '0;
            for (int j = 0; j < 8; j++) b = {b[6:0], bits.pop_front()};
            expq.push_back(b);
        end
    endtask

    task automatic model_eos();
        logic [7:0] b;
        if (bits.size() != 0) begin
            b = '0;
            for (int j = 0; j < 8; j++)
                b = {b[6:0], (bits.size() != 0) ? bits.pop_front() : 1'b0};
            expq.push_back(b);
        end
    endtask

    task automatic send_word(input bit v, input int len);
        logic [COUNT_W-1:0] l;
        l = COUNT_W'(len);
        @(posedge clk); #1;
        fifo.push_back({v, l});
        model_word(v, len);
    endtask

    task automatic pulse_eos();
        @(posedge clk); #1;
        end_of_stream = 1'b1;
        @(posedge clk); #1;
        end_of_stream = 1'b0;
        model_eos();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((fifo.size() != 0 || got.size() < expq.size()) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 3000)
            $display("FAIL %s drain timeout: got %0d bytes, want %0d",
                     tag, got.size(), expq.size());
        else
            passes++;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got.delete();
        expq.delete();
        rd_count = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_data, rd_req, wr_req} !== 10'd0)
            $display("FAIL reset_outputs: out=%h rd=%b wr=%b want 0", out_data, rd_req, wr_req);
        else passes++;
`ifdef RLE_DEC_STATS_EN
        checks++;
        if (byte_count !== 32'd0 || zero_run_err !== 1'b0)
            $display("FAIL reset_stats: count=%0d err=%b want 0", byte_count, zero_run_err);
        else passes++;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_full_byte();
        clear_logs();
        send_word(1'b1, 8);
        drain("full_byte");
        checks++;
        if (got.size() !== 1 || (got.size() == 1 && got[0] !== 8'hFF))
            $display("FAIL full_byte: n=%0d first=%h want 1 x ff", got.size(),
                     got.size() ? got[0] : 8'h00);
        else passes++;
        checks++;
        if (rd_count !== 1)
            $display("FAIL full_byte_rd_pulses: got %0d want 1", rd_count);
        else passes++;
    endtask

    task automatic test_multi_word();
        clear_logs();
        send_word(1'b0, 3);
        send_word(1'b1, 3);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (got.size() !== 0)
            $display("FAIL multi_word_early: got %0d bytes want 0", got.size());
        else passes++;
        send_word(1'b0, 2);
        drain("multi_word");
        checks++;
        if (got.size() !== 1 || (got.size() == 1 && got[0] !== 8'h1C))
            $display("FAIL multi_word: n=%0d first=%h want 1 x 1c", got.size(),
                     got.size() ? got[0] : 8'h00);
        else passes++;
    endtask

    task automatic test_flush();
        clear_logs();
        send_word(1'b1, 3);
        drain("flush_pre");
        pulse_eos();
        drain("flush");
        checks++;
        if (got.size() !== 1 || (got.size() == 1 && got[0] !== 8'hE0))
            $display("FAIL flush: n=%0d first=%h want 1 x e0", got.size(),
                     got.size() ? got[0] : 8'h00);
        else passes++;
        // A lingering end-of-stream flag would flush this half byte early.
        clear_logs();
        send_word(1'b1, 4);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (got.size() !== 0)
            $display("FAIL eos_cleared: got %0d bytes want 0", got.size());
        else passes++;
        send_word(1'b1, 4);
        drain("eos_cleared");
        checks++;
        if (got.size() !== 1 || (got.size() == 1 && got[0] !== 8'hFF))
            $display("FAIL after_flush: n=%0d first=%h want 1 x ff", got.size(),
                     got.size() ? got[0] : 8'h00);
        else passes++;
    endtask

    task automatic test_stall();
        clear_logs();
        send_ready = 1'b0;
        send_word(1'b1, 20);
        repeat (26) @(posedge clk);
        #1;
        checks++;
        if (got.size() !== 0 || out_data !== 8'hFF)
            $display("FAIL stall_hold: n=%0d out=%h want 0, ff", got.size(), out_data);
        else passes++;
        send_ready = 1'b1;
        drain("stall");
        pulse_eos();
        drain("stall_eos");
        checks++;
        if (got.size() !== 3 || (got.size() == 3 &&
            (got[0] !== 8'hFF || got[1] !== 8'hFF || got[2] !== 8'hF0)))
            $display("FAIL stall_bytes: n=%0d want ff ff f0", got.size());
        else passes++;
    endtask

    task automatic test_zero_word();
        clear_logs();
        send_word(1'b1, 0);
        drain("zero_word");
        checks++;
        if (got.size() !== 0 || rd_count !== 1)
            $display("FAIL zero_word: n=%0d rd=%0d want 0, 1", got.size(), rd_count);
        else passes++;
`ifdef RLE_DEC_STATS_EN
        checks++;
        if (zero_run_err !== 1'b1)
            $display("FAIL zero_run_err: got %b want 1", zero_run_err);
        else passes++;
`endif
    endtask

    task automatic test_reset_mid();
        int base;
        clear_logs();
        send_word(1'b1, 12);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        bits.delete();
        expq.delete();
        #1;
        checks++;
        if ({out_data, rd_req, wr_req} !== 10'd0)
            $display("FAIL reset_mid: out=%h rd=%b wr=%b want 0", out_data, rd_req, wr_req);
        else passes++;
        base = wr_total;
        @(posedge clk);
        #1 rst = 1'b0;
        got.delete();
        send_word(1'b0, 8);
        drain("reset_mid");
        checks++;
        if (got.size() !== 1 || (got.size() == 1 && got[0] !== 8'h00))
            $display("FAIL reset_residue: n=%0d first=%h want 1 x 00", got.size(),
                     got.size() ? got[0] : 8'h00);
        else passes++;
`ifdef RLE_DEC_STATS_EN
        checks++;
        if (byte_count !== 32'(wr_total - base) || byte_count !== 32'd1)
            $display("FAIL byte_count: got %0d want 1", byte_count);
        else passes++;
        checks++;
        if (zero_run_err !== 1'b0)
            $display("FAIL zero_run_err_rst: got %b want 0", zero_run_err);
        else passes++;
`endif
    endtask

    task automatic test_random();
        int errs;
        clear_logs();
        bad_wr = 0;
        for (int w = 0; w < 40; w++) begin
            send_word(1'($urandom_range(0, 1)), int'($urandom_range(0, 20)));
            repeat ($urandom_range(0, 6)) begin
                @(posedge clk); #1;
                send_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clk); #1;
        send_ready = 1'b1;
        drain("random");
        pulse_eos();
        drain("random_eos");
        checks++;
        if (got.size() !== expq.size())
            $display("FAIL random_count: got %0d want %0d", got.size(), expq.size());
        else passes++;
        errs = 0;
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            if (got[i] !== expq[i]) begin
                if (errs < 5)
                    $display("FAIL random_byte[%0d]: got %h want %h", i, got[i], expq[i]);
                errs++;
            end
        end
        checks++;
        if (errs != 0) $display("FAIL random_bytes: %0d wrong", errs);
        else passes++;
        checks++;
        if (bad_wr !== 0)
            $display("FAIL wr_without_ready: got %0d want 0", bad_wr);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_full_byte();
        test_multi_word();
        test_flush();
        test_stall();
        test_zero_word();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
